// File: rtl/udma_rx_lin_arbiter.sv
// Round-robin merge of the RX linear channels into one registered L2 write stream.
// Each beat carries the ID of the channel that produced it.
module udma_rx_lin_arbiter #(
   parameter int unsigned N_CH   = 11,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [N_CH-1:0]          ch_valid_i,
   input  logic [N_CH*DATA_W-1:0]   ch_data_i,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
   input  logic [N_CH*2-1:0]        ch_size_i,
   output logic [N_CH-1:0]          ch_ready_o,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [ADDR_W-1:0]        out_addr_o,
   output logic [1:0]               out_size_o,
   output logic [ID_W-1:0]          out_ch_o,
   input  logic                     out_ready_i
);

   logic [DATA_W-1:0] data_arr [N_CH];
   logic [ADDR_W-1:0] addr_arr [N_CH];
   logic [1:0]        size_arr [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign data_arr[k] = ch_data_i[k*DATA_W +: DATA_W];
      assign addr_arr[k] = ch_addr_i[k*ADDR_W +: ADDR_W];
      assign size_arr[k] = ch_size_i[k*2 +: 2];
   end

   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] rr_ptr_d;
   logic [ID_W-1:0] win;
   logic [ID_W-1:0] idx;
   logic            found;
   logic            any_valid;
   logic            can_accept;
   logic            grant;
   int unsigned     pos;

   assign any_valid  = |ch_valid_i;
   assign can_accept = !out_valid_o || out_ready_i;
   assign grant      = can_accept && any_valid;

   // Scan rr_ptr, rr_ptr+1, ... with wrap; first valid channel wins.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         pos = int'(rr_ptr_q) + i;
         if (pos >= N_CH) begin
            pos = pos - N_CH;
         end
         idx = ID_W'(pos);
         if (!found && ch_valid_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      ch_ready_o = '0;
      if (grant) begin
         ch_ready_o[win] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (win == ID_W'(N_CH - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_addr_o  <= '0;
         out_size_o  <= '0;
         out_ch_o    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (grant) begin
            out_valid_o <= 1'b1;
            out_data_o  <= data_arr[win];
            out_addr_o  <= addr_arr[win];
            out_size_o  <= size_arr[win];
            out_ch_o    <= win;
         end else if (can_accept) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_udma_rx_lin_arbiter.sv
// Bench for udma_rx_lin_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a last-granted round-robin model.
module tb_udma_rx_lin_arbiter;

   localparam int N_CH = 11;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int IDW  = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [N_CH-1:0]      valid = '0;
   logic [DW-1:0]        data [N_CH];
   logic [AW-1:0]        addr [N_CH];
   logic [1:0]           size [N_CH];
   logic [N_CH*DW-1:0]   ch_data;
   logic [N_CH*AW-1:0]   ch_addr;
   logic [N_CH*2-1:0]    ch_size;
   logic                 out_ready = 1'b0;

   logic [N_CH-1:0]      ch_ready;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic [AW-1:0]        out_addr;
   logic [1:0]           out_size;
   logic [IDW-1:0]       out_ch;

   always_comb begin
      ch_data = '0;
      ch_addr = '0;
      ch_size = '0;
      for (int k = 0; k < N_CH; k++) begin
         ch_data[k*DW +: DW] = data[k];
         ch_addr[k*AW +: AW] = addr[k];
         ch_size[k*2 +: 2]   = size[k];
      end
   end

   udma_rx_lin_arbiter #(
      .N_CH   (N_CH),
      .DATA_W (DW),
      .ADDR_W (AW),
      .ID_W   (IDW)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .ch_valid_i  (valid),
      .ch_data_i   (ch_data),
      .ch_addr_i   (ch_addr),
      .ch_size_i   (ch_size),
      .ch_ready_o  (ch_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_addr_o  (out_addr),
      .out_size_o  (out_size),
      .out_ch_o    (out_ch),
      .out_ready_i (out_ready)
   );

   int checks   = 0;
   int failures = 0;

   // Model: the output register contents and the last channel granted.
   bit          m_valid;
   logic [DW-1:0] m_data;
   logic [AW-1:0] m_addr;
   logic [1:0]  m_size;
   int          m_ch;
   int          m_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_winner();
      for (int k = 1; k <= N_CH; k++) begin
         if (valid[(m_last + k) % N_CH]) return (m_last + k) % N_CH;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_addr  = '0;
      m_size  = '0;
      m_ch    = 0;
      m_last  = N_CH - 1;
   endtask

   // Called at a negedge with inputs already driven; compares, clocks, updates the model.
   task automatic step();
      bit              can;
      int              w;
      logic [N_CH-1:0] e_ready;
      #1;
      can     = !m_valid || out_ready;
      w       = next_winner();
      e_ready = '0;
      if (can && w >= 0) e_ready[w] = 1'b1;
      check("ch_ready", 64'(ch_ready), 64'(e_ready));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_addr", 64'(out_addr), 64'(m_addr));
      check("out_size", 64'(out_size), 64'(m_size));
      check("out_ch", 64'(out_ch), 64'(m_ch));
      @(posedge clk);
      @(negedge clk);
      if (can && w >= 0) begin
         m_valid  = 1;
         m_data   = data[w];
         m_addr   = addr[w];
         m_size   = size[w];
         m_ch     = w;
         m_last   = w;
         valid[w] = 1'b0;
      end else if (can) begin
         m_valid = 0;
      end
   endtask

   task automatic do_reset();
      rstn  = 1'b0;
      valid = '0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_ch", 64'(out_ch), 64'd0);
      check("rst_ch_ready", 64'(ch_ready), 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic load(input int k);
      data[k]  = $urandom;
      addr[k]  = $urandom;
      size[k]  = 2'($urandom_range(0, 3));
      valid[k] = 1'b1;
   endtask

   // Valid must not drop before the channel has been accepted.
   logic [N_CH-1:0] pv = '0;
   logic [N_CH-1:0] pr = '0;
   always @(posedge clk) begin
      if (rstn && ((pv & ~pr & ~valid) != '0)) begin
         failures++;
         $display("FAIL protocol_valid_drop actual=%0h required=%0h", valid, pv & ~pr);
      end
      pv = rstn ? valid : '0;
      pr = ch_ready;
   end

   logic [DW-1:0] held;

   initial begin
      for (int k = 0; k < N_CH; k++) begin
         data[k] = '0;
         addr[k] = '0;
         size[k] = '0;
      end
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 3; i++) step();
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_ch_ready", 64'(ch_ready), 64'd0);

      // Single channel 4
      out_ready = 1'b1;
      data[4] = 32'hA5A5_0004;
      addr[4] = 32'h1C00_0010;
      size[4] = 2'd2;
      valid[4] = 1'b1;
      #1;
      check("single_ready", 64'(ch_ready), 64'h010);
      step();
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_ch", 64'(out_ch), 64'd4);
      check("single_data", 64'(out_data), 64'hA5A5_0004);

      // All channels continuously valid
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         for (int k = 0; k < N_CH; k++) if (!valid[k]) load(k);
         step();
         check("rr_seq_valid", 64'(out_valid), 64'd1);
         check("rr_seq_ch", 64'(out_ch), 64'(i % N_CH));
      end

      // Backpressure for 5 cycles
      for (int k = 0; k < N_CH; k++) if (!valid[k]) load(k);
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_ready", 64'(ch_ready), 64'd0);
         check("bp_data_stable", 64'(out_data), 64'(held));
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(ch_ready), 64'h004);
      step();
      check("bp_release_ch", 64'(out_ch), 64'd2);

      // Wrap around from channel 10 to channel 2
      do_reset();
      out_ready = 1'b1;
      load(9);
      step();
      check("wrap_first", 64'(out_ch), 64'd9);
      load(2);
      load(10);
      step();
      check("wrap_ch10", 64'(out_ch), 64'd10);
      step();
      check("wrap_ch2", 64'(out_ch), 64'd2);
      load(2);
      load(3);
      step();
      check("wrap_ptr3", 64'(out_ch), 64'd3);

      // Mid-stream asynchronous reset
      check("mid_pre_valid", 64'(out_valid), 64'd1);
      do_reset();
      out_ready = 1'b1;
      load(3);
      load(0);
      step();
      check("mid_restart_ch", 64'(out_ch), 64'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N_CH; k++) begin
            if (!valid[k] && $urandom_range(0, 2) == 0) load(k);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
